// File: rtl/mux8to1_pkg.sv
// Shared widths and select type for the 8-to-1 single-bit multiplexer.
// Both the behavioural top and the gate-level twin import this package.
package mux8to1_pkg;

   localparam int N_INPUTS = 8;
   localparam int SEL_W    = 3;

   typedef logic [SEL_W-1:0] sel_t;

   // Builds the select code from the three discrete select pins, MSB first.
   function automatic sel_t make_sel(input logic s2, input logic s1, input logic s0);
      return {s2, s1, s0};
   endfunction

endpackage

// File: rtl/mux8to1_gate_core.sv
// Gate-level twin of the 8-to-1 selector: inverters for the selects,
// one 4-input AND per data input against its select minterm, and an 8-input OR.
module mux8to1_gate_core
   import mux8to1_pkg::*;
(
   input  logic [N_INPUTS-1:0] data,
   input  sel_t                sel,
   output logic                y
);

   wire [SEL_W-1:0]    sel_n;
   wire [N_INPUTS-1:0] prod;
   wire                y_w;

   not u_inv0 (sel_n[0], sel[0]);
   not u_inv1 (sel_n[1], sel[1]);
   not u_inv2 (sel_n[2], sel[2]);

   genvar gi;
   generate
      for (gi = 0; gi < N_INPUTS; gi++) begin : g_term
         wire t0;
         wire t1;
         wire t2;

         // Each term picks the true or complemented select bit to form minterm gi.
         if ((gi & 1) != 0) begin : g_b0
            assign t0 = sel[0];
         end else begin : g_b0n
            assign t0 = sel_n[0];
         end

         if ((gi & 2) != 0) begin : g_b1
            assign t1 = sel[1];
         end else begin : g_b1n
            assign t1 = sel_n[1];
         end

         if ((gi & 4) != 0) begin : g_b2
            assign t2 = sel[2];
         end else begin : g_b2n
            assign t2 = sel_n[2];
         end

         and u_and (prod[gi], data[gi], t2, t1, t0);
      end
   endgenerate

   or u_or (y_w, prod[0], prod[1], prod[2], prod[3],
                 prod[4], prod[5], prod[6], prod[7]);

   assign y = y_w;

endmodule

// File: rtl/mux8to1_pipe.sv
// Single-bit 8-to-1 mux with combinational and registered outputs.
// Define MUX8TO1_XCHECK_EN to add the gate-level twin and the sticky mismatch flag.
module mux8to1_pipe
   import mux8to1_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i0,
   input  logic i1,
   input  logic i2,
   input  logic i3,
   input  logic i4,
   input  logic i5,
   input  logic i6,
   input  logic i7,
   input  logic s0,
   input  logic s1,
   input  logic s2,
   output logic out,
   output logic out_q,
   output logic mismatch
);

   logic [N_INPUTS-1:0] data;
   sel_t                sel;
   logic                out_q_reg;

   assign data = {i7, i6, i5, i4, i3, i2, i1, i0};
   assign sel  = make_sel(s2, s1, s0);

   always_comb begin
      out = 1'b0;
      case (sel)
         3'd0: out = data[0];
         3'd1: out = data[1];
         3'd2: out = data[2];
         3'd3: out = data[3];
         3'd4: out = data[4];
         3'd5: out = data[5];
         3'd6: out = data[6];
         3'd7: out = data[7];
         default: out = 1'bx;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q_reg <= 1'b0;
      end else begin
         out_q_reg <= out;
      end
   end

   assign out_q = out_q_reg;

`ifdef MUX8TO1_XCHECK_EN
   logic gate_out;
   logic mismatch_reg;

   mux8to1_gate_core u_gate_core (
      .data (data),
      .sel  (sel),
      .y    (gate_out)
   );

   // Sticky: once the two implementations disagree the flag holds until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch_reg <= 1'b0;
      end else if (gate_out != out) begin
         mismatch_reg <= 1'b1;
      end
   end

   assign mismatch = mismatch_reg;
`else
   assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mux8to1_pipe.sv
// Directed, table-driven bench for mux8to1_pipe: select sweep, one-hot data,
// registered latency, async reset and (with MUX8TO1_XCHECK_EN) the sticky cross-check.
module tb_mux8to1_pipe;

   logic clk;
   logic rst_n;
   logic i0, i1, i2, i3, i4, i5, i6, i7;
   logic s0, s1, s2;
   logic out;
   logic out_q;
   logic mismatch;

   int tests_run;
   int tests_failed;

   // data[n] drives input i<n>
   typedef struct {
      logic [7:0] data;
      logic [2:0] sel;
      logic       exp;
   } vec_t;

   vec_t vecs[24];

   mux8to1_pipe dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i0       (i0),
      .i1       (i1),
      .i2       (i2),
      .i3       (i3),
      .i4       (i4),
      .i5       (i5),
      .i6       (i6),
      .i7       (i7),
      .s0       (s0),
      .s1       (s1),
      .s2       (s2),
      .out      (out),
      .out_q    (out_q),
      .mismatch (mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_data(input logic [7:0] d);
      {i7, i6, i5, i4, i3, i2, i1, i0} = d;
   endtask

   task automatic set_sel(input logic [2:0] s);
      {s2, s1, s0} = s;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic prev_out;

      tests_run    = 0;
      tests_failed = 0;

      // One-hot i5 across all codes: only sel=5 yields 1.
      for (int k = 0; k < 8; k++) begin
         vecs[k].data = 8'b0010_0000;
         vecs[k].sel  = 3'(k);
         vecs[k].exp  = (k == 5) ? 1'b1 : 1'b0;
      end
      // Pattern i0=0,i1=1,...,i7=1: out equals select bit 0.
      for (int k = 0; k < 8; k++) begin
         vecs[8 + k].data = 8'b1010_1010;
         vecs[8 + k].sel  = 3'(k);
         vecs[8 + k].exp  = (k % 2 == 1) ? 1'b1 : 1'b0;
      end
      // Inverted one-hot (i2=0, rest 1) and a mixed word.
      vecs[16] = '{8'b1111_1011, 3'd2, 1'b0};
      vecs[17] = '{8'b1111_1011, 3'd3, 1'b1};
      vecs[18] = '{8'b1111_1011, 3'd0, 1'b1};
      vecs[19] = '{8'b1001_0110, 3'd1, 1'b1};
      vecs[20] = '{8'b1001_0110, 3'd3, 1'b0};
      vecs[21] = '{8'b1001_0110, 3'd4, 1'b1};
      vecs[22] = '{8'b1001_0110, 3'd6, 1'b0};
      vecs[23] = '{8'b1001_0110, 3'd7, 1'b1};

      // Reset with clocks running: registered outputs held at 0.
      rst_n = 1'b0;
      set_data(8'hFF);
      set_sel(3'd0);
      tick();
      tick();
      check("reset_out_q", out_q, 1'b0);
      check("reset_mismatch", mismatch, 1'b0);
      check("reset_out_comb", out, 1'b1);
      rst_n = 1'b1;
      #1;
      check("release_out_q_before_edge", out_q, 1'b0);
      tick();
      check("release_first_edge", out_q, 1'b1);

      // Table: combinational value, then registered copy one edge later.
      for (int k = 0; k < 24; k++) begin
         set_data(vecs[k].data);
         set_sel(vecs[k].sel);
         #1;
         check($sformatf("vec%0d_out", k), out, vecs[k].exp);
         tick();
         check($sformatf("vec%0d_out_q", k), out_q, vecs[k].exp);
         check($sformatf("vec%0d_mismatch", k), mismatch, 1'b0);
         $display("[TB] vec %0d data=%b sel=%0d out=%b out_q=%b", k,
                  vecs[k].data, vecs[k].sel, out, out_q);
      end

      // Select sweep: s0/s1/s2 form a counter stepping every 10 ns for 200 ns.
      set_data(8'b1010_1010);
      for (int t = 0; t < 20; t++) begin
         set_sel(3'(t % 8));
         #1;
         check($sformatf("sweep%0d_out", t), out, s0);
         prev_out = s0;
         tick();
         check($sformatf("sweep%0d_out_q", t), out_q, prev_out);
         check($sformatf("sweep%0d_mismatch", t), mismatch, 1'b0);
         $display("[TB] sweep %0d sel=%0d out=%b out_q=%b mismatch=%b",
                  t, {s2, s1, s0}, out, out_q, mismatch);
      end

      // Registered latency: i7 rises then falls between edges.
      set_data(8'h00);
      set_sel(3'd7);
      tick();
      check("lat_pre_out_q", out_q, 1'b0);
      i7 = 1'b1;
      #1;
      check("lat_rise_out", out, 1'b1);
      check("lat_rise_out_q_hold", out_q, 1'b0);
      tick();
      check("lat_rise_out_q", out_q, 1'b1);
      i7 = 1'b0;
      #1;
      check("lat_fall_out_q_hold", out_q, 1'b1);
      tick();
      check("lat_fall_out_q", out_q, 1'b0);
      $display("[TB] latency sequence done out_q=%b", out_q);

      // Simultaneous data and select change before an edge.
      set_data(8'b0100_0000);
      set_sel(3'd6);
      tick();
      check("simul_change_out_q", out_q, 1'b1);

      // Async reset mid-cycle: no edge between assertion and check.
      set_data(8'b0000_1000);
      set_sel(3'd3);
      tick();
      check("areset_pre_out_q", out_q, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_out_q", out_q, 1'b0);
      check("areset_out", out, 1'b1);
      i3 = 1'b0;
      #1;
      check("areset_out_tracks", out, 1'b0);
      i3 = 1'b1;
      tick();
      check("areset_held_out_q", out_q, 1'b0);
      rst_n = 1'b1;
      tick();
      check("areset_release_out_q", out_q, 1'b1);
      check("areset_release_mismatch", mismatch, 1'b0);
      $display("[TB] async reset sequence done out_q=%b", out_q);

`ifdef MUX8TO1_XCHECK_EN
      // Corrupt the gate-level result for one cycle; flag must stick.
      set_data(8'b0000_0010);
      set_sel(3'd1);
      #1;
      force dut.gate_out = 1'b0;
      tick();
      release dut.gate_out;
      check("xchk_set", mismatch, 1'b1);
      tick();
      tick();
      check("xchk_sticky", mismatch, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("xchk_reset_clear", mismatch, 1'b0);
      rst_n = 1'b1;
      tick();
      check("xchk_after_reset", mismatch, 1'b0);
      $display("[TB] cross-check sequence done mismatch=%b", mismatch);
`else
      // No twin: mismatch stays 0 even across a reset pulse.
      #2;
      rst_n = 1'b0;
      #1;
      check("nochk_reset_mismatch", mismatch, 1'b0);
      rst_n = 1'b1;
      tick();
      check("nochk_after_mismatch", mismatch, 1'b0);
      $display("[TB] macro-off sequence done mismatch=%b", mismatch);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mux8to1_pipe.md
# mux8to1_pipe

Single-bit 8-to-1 multiplexer with a combinational path and a registered output. The behavioural select function has a gate-level twin for equivalence cross-checking. Sits in datapath glue logic wherever one of eight scalar signals is steered onto a single line by a 3-bit select, and a clean registered copy is also wanted.

## Interface
Parameters:
- none; widths are fixed by the shared package.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- i0 … i7  in  1 each  data inputs; index n is selected when select value = n
- s0  in  1  select bit 0 (LSB)
- s1  in  1  select bit 1
- s2  in  1  select bit 2 (MSB)
- out  out  1  combinational selected data
- out_q  out  1  registered copy of out
- mismatch  out  1  sticky equivalence-error flag

## Operation
- Select value sel = {s2,s1,s0}, range 0–7; out = i[sel]. For example, sel=3'b101 gives out=i5.
- out is purely combinational:
  - no clock dependence;
  - unaffected by rst_n.
- All eight select codes are legal; there is no default or invalid case.
- X/Z on a select bit: the behavioural path may propagate X, and no recovery is required.
- out_q captures out on every rising clk edge. It has no enable.
- mismatch:
  - set to 1 at a rising clk edge when the gate-level result differs from the behavioural result;
  - stays 1 until rst_n is asserted.

## Timing
- out: zero-cycle latency. It follows any input or select change within the same delta/propagation.
- out_q: one-cycle latency; out_q(t+1) = out sampled at edge t.
- Reset values: out_q = 0, mismatch = 0. Both are forced immediately when rst_n falls, independent of clk.
- Reset release: the first update happens at the first rising clk edge with rst_n=1.
- Reset mid-operation: registered state is lost, and out continues tracking the inputs.
- Simultaneous select and data change before an edge: out_q reflects the settled combinational value at that edge.

## Configuration
- Macro MUX8TO1_XCHECK_EN.
- When defined:
  - the gate-level twin is instantiated;
  - its output is compared to the behavioural output every cycle;
  - mismatch behaves as described in Operation.
- When undefined:
  - no gate-level instance;
  - mismatch is tied to constant 0, including during and after reset.
- out and out_q are identical in both builds.

## Structure
- Package mux8to1_pkg:
  - N_INPUTS = 8;
  - SEL_W = 3;
  - a typedef for the 3-bit select value.
- Sub-module mux8to1_gate_core is the gate-level twin. It is built from primitive gates only:
  - three inverters for the complemented selects;
  - eight 4-input ANDs, each combining one data input with a select minterm;
  - one 8-input OR.
- Top level contains:
  - the behavioural case/index selection;
  - the out_q flop;
  - the compare logic and the sticky mismatch flop;
  - the conditional gate-core instance.

## Test plan
- Select sweep:
  - stimulus: {i0..i7}=8'b01010101 (i0=0, i1=1, …, i7=1); s0 toggles every 10 ns, s1 every 20 ns, s2 every 40 ns, for 200 ns;
  - required: out = s0 throughout (0,1,0,1,…) and mismatch stays 0.
- One-hot data:
  - stimulus: i5=1, all other inputs 0;
  - required: out=1 only at sel=5 and 0 at the other seven codes.
- Registered latency:
  - stimulus: set sel=7 with i7=1, then set i7=0 before the next edge;
  - required: out_q goes 1 one edge after i7 rises and returns to 0 one edge after i7 falls.
- Async reset:
  - stimulus: out_q=1, then drive rst_n low mid-cycle;
  - required: out_q=0 immediately, with no clock edge needed; out still equals the selected input.
- Cross-check (MUX8TO1_XCHECK_EN defined):
  - stimulus: force the gate-core output to the inverse of the correct value for one cycle;
  - required: mismatch=1 at that edge and it stays 1 until rst_n is pulsed low.
- Macro off:
  - stimulus: the select-sweep pattern;
  - required: mismatch constant 0, and out/out_q identical to the macro-on build.
